// File: rtl/regfile_port_scheduler_pkg.sv
// Shared types and helpers for the register-file port scheduler.
package regfile_port_scheduler_pkg;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  // Upper bound on register count supported by the one-hot helper.
  localparam int MAX_REGS = 64;

  function automatic int addr_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_REGS-1:0] onehot(input int idx);
    return MAX_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile_port_scheduler_alloc.sv
// Round-robin client-to-port allocator with same-register hazard blocking.
module rr_port_allocator
  import regfile_port_scheduler_pkg::*;
#(
  parameter int N    = 4,
  parameter int RWP  = 2,
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int IW   = 2
) (
  input  logic [IW-1:0]           rr_ptr,
  input  logic [N-1:0]            valid,
  input  logic [N-1:0]            write,
  input  logic [N-1:0][AW-1:0]    addr,
  output logic [N-1:0]            grant,
  output logic [RWP-1:0][IW-1:0]  port_client,
  output logic [RWP-1:0]          port_used,
  output logic [IW-1:0]           last_idx
);

  always_comb begin
    logic [NREG-1:0] rd_mask, wr_mask;
    int nport, c, a;
    logic hit;
    rd_mask     = '0;
    wr_mask     = '0;
    nport       = 0;
    c           = 0;
    a           = 0;
    hit         = 1'b0;
    grant       = '0;
    port_client = '0;
    port_used   = '0;
    last_idx    = rr_ptr;
    for (int k = 0; k < N; k++) begin
      c = (int'(rr_ptr) + k) % N;
      a = int'(addr[c]);
      // Out-of-range addresses are never granted; the client simply stalls.
      if (nport < RWP && valid[c] && a < NREG) begin
        hit = write[c] ? (rd_mask[a] | wr_mask[a]) : wr_mask[a];
        if (!hit) begin
          grant[c]           = 1'b1;
          port_client[nport] = IW'(c);
          port_used[nport]   = 1'b1;
          last_idx           = IW'(c);
          if (write[c]) wr_mask[a] = 1'b1;
          else          rd_mask[a] = 1'b1;
          nport++;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_port_scheduler.sv
// Shares the register-file ports among clients; zeroes the file after reset.
module regfile_port_scheduler
  import regfile_port_scheduler_pkg::*;
#(
  parameter  int DATA_WIDTH       = 32,
  parameter  int NUM_REGISTERS    = 4,
  parameter  int READ_WRITE_PORTS = 2,
  parameter  int NUM_REQUESTERS   = 4,
  localparam int ADDR_WIDTH       = addr_bits(NUM_REGISTERS)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [NUM_REQUESTERS-1:0]              req_valid_i,
  input  logic [NUM_REQUESTERS-1:0]              req_write_i,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQUESTERS-1:0]              req_ready_o,
  output logic [NUM_REQUESTERS-1:0]              resp_valid_o,
  output logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   resp_data_o,
  output logic [NUM_REGISTERS*READ_WRITE_PORTS-1:0] rf_register_select_o,
  output logic [DATA_WIDTH*READ_WRITE_PORTS-1:0] rf_data_o,
  output logic [READ_WRITE_PORTS-1:0]            rf_write_select_o,
  input  logic [DATA_WIDTH*READ_WRITE_PORTS-1:0] rf_data_i,
  output logic                                   busy_o
);

  localparam int N    = NUM_REQUESTERS;
  localparam int RWP  = READ_WRITE_PORTS;
  localparam int NREG = NUM_REGISTERS;
  localparam int DW   = DATA_WIDTH;
  localparam int AW   = ADDR_WIDTH;
  localparam int IW   = addr_bits(N);
  localparam int INIT_CYCLES = (NREG + RWP - 1) / RWP;
  localparam int CW   = addr_bits(INIT_CYCLES);

  logic [N-1:0][AW-1:0]    addr;
  logic [N-1:0][DW-1:0]    wdata;
  logic [RWP-1:0][DW-1:0]  rd_data;
  logic [RWP-1:0][NREG-1:0] sel;
  logic [RWP-1:0][DW-1:0]  pdata;
  logic [RWP-1:0]          wsel;

  state_e                  state;
  logic [CW-1:0]           init_cnt;
  logic [IW-1:0]           rr_ptr;
  logic [N-1:0]            resp_valid;
  logic [N-1:0][DW-1:0]    resp_data, resp_next;

  logic [N-1:0]            grant;
  logic [RWP-1:0][IW-1:0]  port_client;
  logic [RWP-1:0]          port_used;
  logic [IW-1:0]           last_idx;
  logic                    run;

  assign addr    = req_addr_i;
  assign wdata   = req_data_i;
  assign rd_data = rf_data_i;
  assign run     = (state == ST_RUN);

  rr_port_allocator #(.N(N), .RWP(RWP), .NREG(NREG), .AW(AW), .IW(IW)) u_alloc (
    .rr_ptr      (rr_ptr),
    .valid       (req_valid_i & {N{run}}),
    .write       (req_write_i),
    .addr        (addr),
    .grant       (grant),
    .port_client (port_client),
    .port_used   (port_used),
    .last_idx    (last_idx)
  );

  always_comb begin
    logic [MAX_REGS-1:0] oh;
    int idx;
    oh        = '0;
    idx       = 0;
    sel       = '0;
    wsel      = '0;
    pdata     = '0;
    resp_next = resp_data;
    for (int p = 0; p < RWP; p++) begin
      oh = onehot(0);
      if (!run) begin
        // Init sweep: port p zeroes register init_cnt*RWP + p when it exists.
        idx = int'(init_cnt) * RWP + p;
        if (idx < NREG) begin
          oh      = onehot(idx);
          wsel[p] = 1'b1;
        end
      end else if (port_used[p]) begin
        oh       = onehot(int'(addr[port_client[p]]));
        wsel[p]  = req_write_i[port_client[p]];
        pdata[p] = wdata[port_client[p]];
        resp_next[port_client[p]] = req_write_i[port_client[p]] ? wdata[port_client[p]]
                                                                 : rd_data[p];
      end
      sel[p] = oh[NREG-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      rr_ptr     <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= grant;
      resp_data  <= resp_next;
      case (state)
        ST_INIT: begin
          if (init_cnt == CW'(INIT_CYCLES - 1)) state <= ST_RUN;
          else                                  init_cnt <= init_cnt + 1'b1;
        end
        default: begin
          if (|grant) rr_ptr <= IW'((int'(last_idx) + 1) % N);
        end
      endcase
    end
  end

  always_ff @(posedge clk_i)
    for (int c = 0; c < N; c++)
      assert (reset_i || !(grant[c] && int'(addr[c]) >= NREG));

  assign req_ready_o          = grant;
  assign resp_valid_o         = resp_valid;
  assign resp_data_o          = resp_data;
  assign rf_register_select_o = sel;
  assign rf_data_o            = pdata;
  assign rf_write_select_o    = wsel;
  assign busy_o               = (state == ST_INIT);

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Scoreboard bench for regfile_port_scheduler with a behavioural register file.
module tb_regfile_port_scheduler;

  localparam int DW = 32, NREG = 4, RWP = 2, N = 4, AW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]        req_valid = '0, req_write = '0, req_ready, resp_valid;
  logic [N*AW-1:0]     req_addr = '0;
  logic [N*DW-1:0]     req_data = '0, resp_data;
  logic [NREG*RWP-1:0] rf_sel;
  logic [DW*RWP-1:0]   rf_wdata, rf_rdata;
  logic [RWP-1:0]      rf_we;
  logic                busy;

  int vectors = 0;
  int miscompares = 0;

  // Non-zero power-up contents so the init sweep is observable.
  logic [DW-1:0] rf_mem [NREG] = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
  logic [DW-1:0] shadow [NREG];
  logic [DW-1:0] exp_q  [N][$];

  always #5 clk = ~clk;

  regfile_port_scheduler dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .req_valid_i          (req_valid),
    .req_write_i          (req_write),
    .req_addr_i           (req_addr),
    .req_data_i           (req_data),
    .req_ready_o          (req_ready),
    .resp_valid_o         (resp_valid),
    .resp_data_o          (resp_data),
    .rf_register_select_o (rf_sel),
    .rf_data_o            (rf_wdata),
    .rf_write_select_o    (rf_we),
    .rf_data_i            (rf_rdata),
    .busy_o               (busy)
  );

  function automatic int sel_idx(input logic [NREG-1:0] s);
    int r;
    r = 0;
    for (int i = 0; i < NREG; i++) if (s[i]) r = i;
    return r;
  endfunction

  always_comb begin
    rf_rdata = '0;
    for (int p = 0; p < RWP; p++)
      rf_rdata[p*DW +: DW] = rf_mem[sel_idx(rf_sel[p*NREG +: NREG])];
  end

  always @(posedge clk)
    for (int p = 0; p < RWP; p++)
      if (rf_we[p]) rf_mem[sel_idx(rf_sel[p*NREG +: NREG])] <= rf_wdata[p*DW +: DW];

  // Pop expected responses for last cycle's handshakes, then record this cycle's.
  task automatic sb_step();
    logic [DW-1:0] e;
    int a;
    for (int c = 0; c < N; c++) begin
      if (exp_q[c].size() != 0) begin
        e = exp_q[c].pop_front();
        vectors++;
        if (resp_valid[c] !== 1'b1 || resp_data[c*DW +: DW] !== e) begin
          miscompares++;
          $display("FAIL resp_c%0d: got valid=%b data=%h, want valid=1 data=%h",
                   c, resp_valid[c], resp_data[c*DW +: DW], e);
        end
      end else if (resp_valid[c] !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_resp_c%0d: got valid=%b, want 0", c, resp_valid[c]);
      end
    end
    if (reset) begin
      for (int c = 0; c < N; c++) exp_q[c].delete();
      for (int i = 0; i < NREG; i++) shadow[i] = '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (req_valid[c] && req_ready[c]) begin
          a = int'(req_addr[c*AW +: AW]);
          if (req_write[c]) begin
            exp_q[c].push_back(req_data[c*DW +: DW]);
            shadow[a] = req_data[c*DW +: DW];
          end else begin
            exp_q[c].push_back(shadow[a]);
          end
        end
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    sb_step();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[c]          = v;
    req_write[c]          = w;
    req_addr[c*AW +: AW]  = a;
    req_data[c*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    for (int c = 0; c < N; c++) set_req(c, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    half(); rise();
    reset = 1'b0;
    half(); rise();
    half(); rise();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < N; c++) set_req(c, 1'b1, 1'b0, AW'(c), '0);
    half(); rise();
    half();
    vectors++;
    if (resp_valid !== 4'b0000 || resp_data !== '0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got rv=%b rd=%h busy=%b, want 0 0 1", resp_valid, resp_data, busy);
    end
    rise();
    reset = 1'b0;
    half();
    vectors++;
    if (busy !== 1'b1 || req_ready !== 4'b0000 || rf_we !== 2'b11 ||
        rf_sel !== {4'b0010, 4'b0001} || rf_wdata !== '0) begin
      miscompares++;
      $display("FAIL init_c1: got busy=%b rdy=%b we=%b sel=%b data=%h, want 1 0000 11 00100001 0",
               busy, req_ready, rf_we, rf_sel, rf_wdata);
    end
    rise(); half();
    vectors++;
    if (busy !== 1'b1 || req_ready !== 4'b0000 || rf_we !== 2'b11 || rf_sel !== {4'b1000, 4'b0100}) begin
      miscompares++;
      $display("FAIL init_c2: got busy=%b rdy=%b we=%b sel=%b, want 1 0000 11 10000100",
               busy, req_ready, rf_we, rf_sel);
    end
    rise(); half();
    vectors++;
    if (busy !== 1'b0 || req_ready !== 4'b0011 || rf_we !== 2'b00 || rf_sel !== {4'b0010, 4'b0001}) begin
      miscompares++;
      $display("FAIL run_c3: got busy=%b rdy=%b we=%b sel=%b, want 0 0011 00 00100001",
               busy, req_ready, rf_we, rf_sel);
    end
    rise();
    clear_reqs();
    half(); rise();
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(0, 1'b1, 1'b1, 2'd2, 32'hDEAD_BEEF);
    half();
    vectors++;
    if (req_ready !== 4'b0001 || rf_we !== 2'b01 || rf_sel !== {4'b0001, 4'b0100} ||
        rf_wdata !== {32'h0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL wr_grant: got rdy=%b we=%b sel=%b data=%h, want 0001 01 00010100 0_deadbeef",
               req_ready, rf_we, rf_sel, rf_wdata);
    end
    rise();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 2'd2, '0);
    half();
    vectors++;
    if (resp_valid[0] !== 1'b1 || resp_data[31:0] !== 32'hDEAD_BEEF || req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL wr_ack: got rv=%b d0=%h rdy=%b, want 1 deadbeef 0010",
               resp_valid[0], resp_data[31:0], req_ready);
    end
    rise();
    set_req(1, 1'b0, 1'b0, '0, '0);
    half();
    vectors++;
    if (resp_valid !== 4'b0010 || resp_data[63:32] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL rd_after_wr: got rv=%b d1=%h, want 0010 deadbeef", resp_valid, resp_data[63:32]);
    end
    vectors++;
    if (resp_data[31:0] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL resp_hold: got d0=%h, want deadbeef", resp_data[31:0]);
    end
    rise();
  endtask

  task automatic test_write_conflict();
    do_reset();
    set_req(0, 1'b1, 1'b1, 2'd1, 32'h1111_1111);
    set_req(1, 1'b1, 1'b1, 2'd1, 32'h2222_2222);
    half();
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL ww_first: got rdy=%b, want 0001", req_ready);
    end
    rise();
    set_req(0, 1'b0, 1'b0, '0, '0);
    half();
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL ww_second: got rdy=%b, want 0010", req_ready);
    end
    rise();
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b1, 1'b0, 2'd1, '0);
    half();
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL ww_readback_grant: got rdy=%b, want 0100", req_ready);
    end
    rise();
    set_req(2, 1'b0, 1'b0, '0, '0);
    half();
    vectors++;
    if (resp_valid[2] !== 1'b1 || resp_data[95:64] !== 32'h2222_2222) begin
      miscompares++;
      $display("FAIL ww_final: got rv=%b d2=%h, want 1 22222222", resp_valid[2], resp_data[95:64]);
    end
    rise();
  endtask

  task automatic test_read_share();
    do_reset();
    set_req(3, 1'b1, 1'b1, 2'd3, 32'h55);
    half();
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL rs_setup: got rdy=%b, want 1000", req_ready);
    end
    rise();
    set_req(3, 1'b0, 1'b0, '0, '0);
    set_req(0, 1'b1, 1'b0, 2'd3, '0);
    set_req(2, 1'b1, 1'b0, 2'd3, '0);
    half();
    vectors++;
    if (req_ready !== 4'b0101 || rf_we !== 2'b00 || rf_sel !== {4'b1000, 4'b1000}) begin
      miscompares++;
      $display("FAIL rs_grant: got rdy=%b we=%b sel=%b, want 0101 00 10001000", req_ready, rf_we, rf_sel);
    end
    rise();
    clear_reqs();
    half();
    vectors++;
    if (resp_valid !== 4'b0101 || resp_data[31:0] !== 32'h55 || resp_data[95:64] !== 32'h55) begin
      miscompares++;
      $display("FAIL rs_resp: got rv=%b d0=%h d2=%h, want 0101 55 55",
               resp_valid, resp_data[31:0], resp_data[95:64]);
    end
    rise();
  endtask

  task automatic test_back_to_back();
    int cnt [N];
    logic [N-1:0] want;
    do_reset();
    for (int c = 0; c < N; c++) begin
      cnt[c] = 0;
      set_req(c, 1'b1, 1'b0, AW'(c), '0);
    end
    for (int i = 0; i < 6; i++) begin
      half();
      want = (i % 2 == 0) ? 4'b0011 : 4'b1100;
      vectors++;
      if (req_ready !== want) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got rdy=%b, want %b", i, req_ready, want);
      end
      for (int c = 0; c < N; c++) if (req_ready[c]) cnt[c]++;
      rise();
    end
    clear_reqs();
    half(); rise();
    for (int c = 0; c < N; c++) begin
      vectors++;
      if (cnt[c] != 3) begin
        miscompares++;
        $display("FAIL b2b_fair_c%0d: got %0d grants, want 3", c, cnt[c]);
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_req(0, 1'b1, 1'b1, 2'd0, 32'h1234_5678);
    reset = 1'b1;
    half();
    vectors++;
    if (req_ready[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_hs: got rdy0=%b, want 1", req_ready[0]);
    end
    rise();
    reset = 1'b0;
    clear_reqs();
    half();
    vectors++;
    if (resp_valid !== 4'b0000 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_drop: got rv=%b busy=%b, want 0000 1", resp_valid, busy);
    end
    rise(); half(); rise();
    for (int c = 0; c < N; c++) set_req(c, 1'b1, 1'b0, AW'(c), '0);
    half();
    vectors++;
    if (req_ready !== 4'b0011 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rerun: got rdy=%b busy=%b, want 0011 0", req_ready, busy);
    end
    rise(); half();
    vectors++;
    if (resp_valid[1:0] !== 2'b11 || resp_data[31:0] !== '0 || resp_data[63:32] !== '0) begin
      miscompares++;
      $display("FAIL mid_zero01: got rv=%b d0=%h d1=%h, want 11 0 0",
               resp_valid[1:0], resp_data[31:0], resp_data[63:32]);
    end
    rise();
    clear_reqs();
    half();
    vectors++;
    if (resp_valid !== 4'b1100 || resp_data[95:64] !== '0 || resp_data[127:96] !== '0) begin
      miscompares++;
      $display("FAIL mid_zero23: got rv=%b d2=%h d3=%h, want 1100 0 0",
               resp_valid, resp_data[95:64], resp_data[127:96]);
    end
    rise();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_write_conflict();
    test_read_share();
    test_back_to_back();
    test_reset_midop();
    half(); rise();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
